mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage MIPS pipeline: holds the 4096-word data memory, performs word/half/byte stores with byte lanes, sign- or zero-extends load data, selects the write-back value, and registers everything into the MEM/WB pipeline register. Its registered outputs `pc_MemWb`, `instr_MemWb`, `grfWa_MemWb` and `grfWd_MemWb` feed the write-back stage directly. It also exports a combinational forwarding value for the hazard unit.

## Interface
Parameters:
- `DM_WORDS`, 4096, data-memory depth in 32-bit words; address index is `aluRes_ExMem[13:2]`.

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock; polarity and synchronicity are fixed.
- `pc_ExMem`  in  32  PC of the instruction in MEM.
- `instr_ExMem`  in  32  instruction word; passed through, not decoded here.
- `aluRes_ExMem`  in  32  ALU result; the memory byte address for loads and stores.
- `rtData_ExMem`  in  32  store data, already forwarded.
- `grfWa_ExMem`  in  5  destination register.
- `grfWdSel_ExMem`  in  2  write-back source: 0 ALU result, 1 load data, 2 `pc_ExMem + 8`, 3 reserved (treated as 0).
- `memOp_ExMem`  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 8 sw, 9 sh, 10 sb; any other value is treated as none.
- `fwdData_Mem`  out  32  combinational: `pc_ExMem+8` when sel=2, else `aluRes_ExMem`. Never the load data.
- `pc_MemWb`  out  32  registered PC.
- `instr_MemWb`  out  32  registered instruction.
- `grfWa_MemWb`  out  5  registered destination.
- `grfWd_MemWb`  out  32  registered write-back data.

## Operation
- Address decomposition:
  - word index `a = aluRes_ExMem[13:2]`; byte offset `b = aluRes_ExMem[1:0]`.
  - Upper address bits are ignored, so addresses wrap modulo 16 KiB.
  - No alignment exceptions: lw/sw ignore `b`; lh/lhu/sh ignore `b[0]`.
- Stores, little-endian, written at the rising edge:
  - sw: whole word at `a`.
  - sh: `rtData[15:0]` into the halfword selected by `b[1]` (0 = bits 15:0, 1 = bits 31:16); the other half is unchanged.
  - sb: `rtData[7:0]` into byte lane `b` (lane 0 = bits 7:0); the other lanes are unchanged.
- Loads, combinational read of `dm[a]`:
  - lw: the whole word.
  - lh/lhu: the halfword selected by `b[1]`, sign- or zero-extended to 32 bits.
  - lb/lbu: byte lane `b`, sign- or zero-extended to 32 bits.
- Write-back select: `wd = sel==1 ? loadData : sel==2 ? pc_ExMem+8 : aluRes_ExMem`. `pc+8` is a 32-bit wrap-around add.
- MEM/WB register, every non-reset edge (no stall, no flush; `$0` filtering is done downstream):
  - `pc_MemWb` ← `pc_ExMem`; `instr_MemWb` ← `instr_ExMem`.
  - `grfWa_MemWb` ← `grfWa_ExMem`; `grfWd_MemWb` ← `wd`.
- Reset (synchronous):
  - All four registered outputs become 0.
  - Every DM word becomes 0.
  - Any store presented in the reset cycle is discarded.

## Timing
- Store latency is one edge: a load in the next cycle to the same word returns the new data.
- A single instruction never both loads and stores, so there is no same-cycle read/write hazard.
- Load-to-output latency is one cycle: `grfWd_MemWb` holds the load value one edge after the load is in MEM.
- `fwdData_Mem` is purely combinational from the current EX/MEM inputs, with zero latency. The hazard unit must stall load-use dependences on MEM.
- Reset mid-pipeline: at the reset edge the outputs go to 0 and memory is cleared. The first post-reset edge captures the inputs normally.
- All stores write exactly one word index, so there are no multi-cycle operations and no handshakes.

## Test plan
- **Word store then load:** sw `0x12345678` to `0x0000_0010`, then lw `0x10` with sel=1 and grfWa=8 -> one edge later `grfWd_MemWb=0x12345678`, `grfWa_MemWb=8`.
- **Byte stores and byte loads:**
  - After word 0 = `0x00000000`: sb `0xAA` at `0x1`, then sb `0x80` at `0x3`, then lw `0x0` -> `0x8000AA00`.
  - lb `0x3` -> `0xFFFFFF80`; lbu `0x3` -> `0x00000080`.
- **Halfword stores and loads:**
  - sh `0xBEEF` at `0x22`, then lw `0x20` with prior word `0x11112222` -> `0xBEEF2222`.
  - lh `0x22` -> `0xFFFFBEEF`; lhu `0x22` -> `0x0000BEEF`.
- **PC+8 select and forwarding:** sel=2, `pc_ExMem=0x00003010` -> `fwdData_Mem=0x00003018` in the same cycle and `grfWd_MemWb=0x00003018` after the edge. With sel=0 and `aluRes=0x7` -> `fwdData_Mem=0x7`.
- **Address wrap:** sw `0xCAFEF00D` to `0x0000_4004`, then lw `0x0000_0004` -> `0xCAFEF00D`.
- **Reset mid-operation:** store a nonzero word, then assert reset for one cycle while an sw is presented. Afterwards all four MEM/WB outputs read 0, and lw of both addresses returns 0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Holds the data memory, performs word/half/byte stores using byte lanes,
// sign/zero-extends load data, picks the write-back value and registers
// everything into the MEM/WB pipeline register.
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   reset          in   synchronous active-high reset (clears MEM/WB and DM)
//   pc_ExMem       in   PC of the instruction in MEM
//   instr_ExMem    in   instruction word, passed through
//   aluRes_ExMem   in   ALU result / memory byte address
//   rtData_ExMem   in   store data
//   grfWa_ExMem    in   destination register
//   grfWdSel_ExMem in   write-back source: 0 ALU, 1 load, 2 pc+8, 3 ALU
//   memOp_ExMem    in   0 none,1 lw,2 lh,3 lhu,4 lb,5 lbu,8 sw,9 sh,10 sb
//   fwdData_Mem    out  combinational forward value (pc+8 or ALU result)
//   pc_MemWb, instr_MemWb, grfWa_MemWb, grfWd_MemWb  out  MEM/WB register
module mem_stage #(
  parameter int unsigned DM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_ExMem,
  input  logic [31:0] instr_ExMem,
  input  logic [31:0] aluRes_ExMem,
  input  logic [31:0] rtData_ExMem,
  input  logic [4:0]  grfWa_ExMem,
  input  logic [1:0]  grfWdSel_ExMem,
  input  logic [3:0]  memOp_ExMem,
  output logic [31:0] fwdData_Mem,
  output logic [31:0] pc_MemWb,
  output logic [31:0] instr_MemWb,
  output logic [4:0]  grfWa_MemWb,
  output logic [31:0] grfWd_MemWb
);

  // DM_WORDS is expected to be a power of two so the index is a plain slice.
  localparam int unsigned AW = $clog2(DM_WORDS);

  localparam logic [3:0] OpLw  = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLhu = 4'd3;
  localparam logic [3:0] OpLb  = 4'd4;
  localparam logic [3:0] OpLbu = 4'd5;
  localparam logic [3:0] OpSw  = 4'd8;
  localparam logic [3:0] OpSh  = 4'd9;
  localparam logic [3:0] OpSb  = 4'd10;

  logic [31:0] r_dm [DM_WORDS];

  logic [AW-1:0] w_addr;
  logic [1:0]    w_off;
  logic [31:0]   w_word;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic [31:0]   w_load;
  logic [31:0]   w_wr_word;
  logic          w_we;
  logic [31:0]   w_pc8;
  logic [31:0]   w_wd;
  logic          w_unused_addr;

  assign w_addr = aluRes_ExMem[AW+1:2];
  assign w_off  = aluRes_ExMem[1:0];
  // Upper address bits are deliberately dropped: the address space wraps.
  assign w_unused_addr = ^aluRes_ExMem[31:AW+2];

  assign w_word = r_dm[w_addr];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_pc8  = pc_ExMem + 32'd8;

  always_comb begin
    w_load = '0;
    case (memOp_ExMem)
      OpLw:    w_load = w_word;
      OpLh:    w_load = {{16{w_half[15]}}, w_half};
      OpLhu:   w_load = {16'h0000, w_half};
      OpLb:    w_load = {{24{w_byte[7]}}, w_byte};
      OpLbu:   w_load = {24'h000000, w_byte};
      default: w_load = '0;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep the current word.
  always_comb begin
    w_wr_word = w_word;
    w_we      = 1'b0;
    case (memOp_ExMem)
      OpSw: begin
        w_we      = 1'b1;
        w_wr_word = rtData_ExMem;
      end
      OpSh: begin
        w_we = 1'b1;
        if (w_off[1]) w_wr_word[31:16] = rtData_ExMem[15:0];
        else          w_wr_word[15:0]  = rtData_ExMem[15:0];
      end
      OpSb: begin
        w_we = 1'b1;
        w_wr_word[{w_off, 3'b000} +: 8] = rtData_ExMem[7:0];
      end
      default: begin
        w_we      = 1'b0;
        w_wr_word = w_word;
      end
    endcase
  end

  always_comb begin
    w_wd = aluRes_ExMem;
    case (grfWdSel_ExMem)
      2'd1:    w_wd = w_load;
      2'd2:    w_wd = w_pc8;
      default: w_wd = aluRes_ExMem;
    endcase
  end

  // Forwarding never carries load data; load-use hazards are stalled upstream.
  assign fwdData_Mem = (grfWdSel_ExMem == 2'd2) ? w_pc8 : aluRes_ExMem;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_dm[i] <= '0;
      pc_MemWb    <= '0;
      instr_MemWb <= '0;
      grfWa_MemWb <= '0;
      grfWd_MemWb <= '0;
    end else begin
      if (w_we) r_dm[w_addr] <= w_wr_word;
      pc_MemWb    <= pc_ExMem;
      instr_MemWb <= instr_ExMem;
      grfWa_MemWb <= grfWa_ExMem;
      grfWd_MemWb <= w_wd;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: byte-addressed reference memory model plus a
// per-cycle compare process, and literal expectations from hand calculation.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_ExMem, instr_ExMem, aluRes_ExMem, rtData_ExMem;
  logic [4:0]  grfWa_ExMem;
  logic [1:0]  grfWdSel_ExMem;
  logic [3:0]  memOp_ExMem;
  logic [31:0] fwdData_Mem, pc_MemWb, instr_MemWb, grfWd_MemWb;
  logic [4:0]  grfWa_MemWb;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.DM_WORDS(4096)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_ExMem       (pc_ExMem),
    .instr_ExMem    (instr_ExMem),
    .aluRes_ExMem   (aluRes_ExMem),
    .rtData_ExMem   (rtData_ExMem),
    .grfWa_ExMem    (grfWa_ExMem),
    .grfWdSel_ExMem (grfWdSel_ExMem),
    .memOp_ExMem    (memOp_ExMem),
    .fwdData_Mem    (fwdData_Mem),
    .pc_MemWb       (pc_MemWb),
    .instr_MemWb    (instr_MemWb),
    .grfWa_MemWb    (grfWa_MemWb),
    .grfWd_MemWb    (grfWd_MemWb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: 16 KiB little-endian byte array -------
  logic [7:0]  m_mem [16384];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_pc, exp_instr, exp_wd;
  logic [4:0]  exp_wa;

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr);
    int ba;
    int wb;
    int hb;
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    ba = int'(addr[13:0]);
    wb = ba - (ba % 4);
    hb = wb + (addr[1] ? 2 : 0);
    w  = {m_mem[wb+3], m_mem[wb+2], m_mem[wb+1], m_mem[wb]};
    h  = {m_mem[hb+1], m_mem[hb]};
    b  = m_mem[ba];
    case (op)
      4'd1:    return w;
      4'd2:    return 32'($signed(h));
      4'd3:    return 32'(h);
      4'd4:    return 32'($signed(b));
      4'd5:    return 32'(b);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_fwd();
    return (grfWdSel_ExMem == 2'd2) ? pc_ExMem + 32'd8 : aluRes_ExMem;
  endfunction

  always @(posedge clk) begin
    int ba;
    int wb;
    logic [31:0] ld;
    if (reset) begin
      for (int i = 0; i < 16384; i++) m_mem[i] = 8'h00;
      exp_pc = 0; exp_instr = 0; exp_wa = 0; exp_wd = 0;
      exp_valid = 1'b1;
    end else begin
      ld = m_load(memOp_ExMem, aluRes_ExMem);
      exp_pc    = pc_ExMem;
      exp_instr = instr_ExMem;
      exp_wa    = grfWa_ExMem;
      exp_wd    = (grfWdSel_ExMem == 2'd1) ? ld : m_fwd();
      ba = int'(aluRes_ExMem[13:0]);
      wb = ba - (ba % 4);
      case (memOp_ExMem)
        4'd8: for (int k = 0; k < 4; k++) m_mem[wb+k] = rtData_ExMem[8*k +: 8];
        4'd9: begin
          m_mem[wb + (aluRes_ExMem[1] ? 2 : 0)]     = rtData_ExMem[7:0];
          m_mem[wb + (aluRes_ExMem[1] ? 2 : 0) + 1] = rtData_ExMem[15:8];
        end
        4'd10: m_mem[ba] = rtData_ExMem[7:0];
        default: ;
      endcase
    end
  end

  // Per-cycle compare, on the falling edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("pc_MemWb", pc_MemWb, exp_pc);
      check("instr_MemWb", instr_MemWb, exp_instr);
      check("grfWa_MemWb", {27'd0, grfWa_MemWb}, {27'd0, exp_wa});
      check("grfWd_MemWb", grfWd_MemWb, exp_wd);
      check("fwdData_Mem", fwdData_Mem, m_fwd());
    end
  end

  // Present one instruction for the next rising edge.
  task automatic step(input logic rst, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] sel, input logic [4:0] wa,
                      input logic [31:0] pc);
    @(posedge clk);
    #2;
    reset          = rst;
    memOp_ExMem    = op;
    aluRes_ExMem   = addr;
    rtData_ExMem   = data;
    grfWdSel_ExMem = sel;
    grfWa_ExMem    = wa;
    pc_ExMem       = pc;
    instr_ExMem    = pc ^ 32'hA5A5_0F0F;
  endtask

  initial begin
    reset = 1'b1;
    memOp_ExMem = 0; aluRes_ExMem = 0; rtData_ExMem = 0; grfWdSel_ExMem = 0;
    grfWa_ExMem = 0; pc_ExMem = 0; instr_ExMem = 0;
    step(1, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h0);
    step(0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h0);
    #1;
    check("reset_wd", grfWd_MemWb, 32'h0);
    check("reset_pc", pc_MemWb, 32'h0);

    // Word store then load.
    step(0, 4'd8, 32'h10, 32'h12345678, 2'd0, 5'd0, 32'h100);
    step(0, 4'd1, 32'h10, 32'h0, 2'd1, 5'd8, 32'h104);
    step(0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h108);
    check("sw_lw_wd", grfWd_MemWb, 32'h12345678);
    check("sw_lw_wa", {27'd0, grfWa_MemWb}, 32'd8);

    // Byte stores / loads.
    step(0, 4'd8, 32'h0, 32'h0, 2'd0, 5'd0, 32'h200);
    step(0, 4'd10, 32'h1, 32'hFFFF_FFAA, 2'd0, 5'd0, 32'h204);
    step(0, 4'd10, 32'h3, 32'h0000_0080, 2'd0, 5'd0, 32'h208);
    step(0, 4'd1, 32'h0, 32'h0, 2'd1, 5'd9, 32'h20C);
    step(0, 4'd4, 32'h3, 32'h0, 2'd1, 5'd9, 32'h210);
    check("sb_lw", grfWd_MemWb, 32'h8000AA00);
    step(0, 4'd5, 32'h3, 32'h0, 2'd1, 5'd9, 32'h214);
    check("lb", grfWd_MemWb, 32'hFFFFFF80);
    step(0, 4'd4, 32'h1, 32'h0, 2'd1, 5'd9, 32'h218);
    check("lbu", grfWd_MemWb, 32'h00000080);
    step(0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h21C);
    check("lb_lane1", grfWd_MemWb, 32'hFFFFFFAA);

    // Halfword stores / loads.
    step(0, 4'd8, 32'h20, 32'h11112222, 2'd0, 5'd0, 32'h300);
    step(0, 4'd9, 32'h22, 32'h1234BEEF, 2'd0, 5'd0, 32'h304);
    step(0, 4'd1, 32'h20, 32'h0, 2'd1, 5'd3, 32'h308);
    step(0, 4'd2, 32'h22, 32'h0, 2'd1, 5'd3, 32'h30C);
    check("sh_lw", grfWd_MemWb, 32'hBEEF2222);
    step(0, 4'd3, 32'h22, 32'h0, 2'd1, 5'd3, 32'h310);
    check("lh", grfWd_MemWb, 32'hFFFFBEEF);
    step(0, 4'd2, 32'h21, 32'h0, 2'd1, 5'd3, 32'h314);
    check("lhu", grfWd_MemWb, 32'h0000BEEF);
    step(0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h318);
    check("lh_low", grfWd_MemWb, 32'h00002222);

    // PC+8 select and forwarding.
    step(0, 4'd0, 32'h55, 32'h0, 2'd2, 5'd31, 32'h00003010);
    #1;
    check("fwd_pc8", fwdData_Mem, 32'h00003018);
    step(0, 4'd0, 32'h7, 32'h0, 2'd0, 5'd1, 32'h00003014);
    #1;
    check("wb_pc8", grfWd_MemWb, 32'h00003018);
    check("fwd_alu", fwdData_Mem, 32'h7);
    step(0, 4'd0, 32'h9, 32'h0, 2'd2, 5'd1, 32'hFFFFFFFC);
    step(0, 4'd0, 32'hABC, 32'h0, 2'd3, 5'd1, 32'h400);
    check("pc8_wrap", grfWd_MemWb, 32'h00000004);
    step(0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h404);
    check("sel3_alu", grfWd_MemWb, 32'h00000ABC);

    // Address wrap, and an undefined op that must not store.
    step(0, 4'd8, 32'h00004004, 32'hCAFEF00D, 2'd0, 5'd0, 32'h500);
    step(0, 4'd11, 32'h4, 32'h0BAD0BAD, 2'd0, 5'd0, 32'h504);
    step(0, 4'd1, 32'h4, 32'h0, 2'd1, 5'd4, 32'h508);
    step(0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h50C);
    check("addr_wrap", grfWd_MemWb, 32'hCAFEF00D);

    // Reset mid-operation with a store presented in the reset cycle.
    step(0, 4'd8, 32'h40, 32'hDEADBEEF, 2'd0, 5'd0, 32'h600);
    step(1, 4'd8, 32'h80, 32'h55555555, 2'd2, 5'd7, 32'h604);
    step(0, 4'd1, 32'h40, 32'h0, 2'd1, 5'd2, 32'h608);
    check("rst_pc", pc_MemWb, 32'h0);
    check("rst_instr", instr_MemWb, 32'h0);
    check("rst_wa", {27'd0, grfWa_MemWb}, 32'h0);
    check("rst_wd", grfWd_MemWb, 32'h0);
    step(0, 4'd1, 32'h80, 32'h0, 2'd1, 5'd2, 32'h60C);
    check("rst_clr_40", grfWd_MemWb, 32'h0);
    step(0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 32'h610);
    check("rst_drop_80", grfWd_MemWb, 32'h0);
    check("post_rst_pc", pc_MemWb, 32'h60C);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
